// File: rtl/cpu_alu_pkg.sv
// Shared types and constants for the CPU ALU scheduler.
// Covers the opcode bit positions, the FSM state encoding and the exec-counter sizing.
package cpu_alu_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned FLAG_W_DEF = 32;

  localparam int unsigned OP_MUL_BIT = 2;
  localparam int unsigned OP_SUB_BIT = 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } aluState_t;

  // Counter only ever reaches maxLat-1, so $clog2(maxLat) bits suffice (min 1).
  function automatic int unsigned latCntW(input int unsigned addLat,
                                          input int unsigned mulLat);
    int unsigned maxLat;
    maxLat = (addLat > mulLat) ? addLat : mulLat;
    return (maxLat <= 2) ? 1 : $clog2(maxLat);
  endfunction

endpackage

// File: rtl/cpu_rr_arb2.sv
// Two-request round-robin arbiter, purely combinational.
// On a tie it grants the port that did not win last time.
module cpu_rr_arb2 (
  input  logic [1:0] req,
  input  logic       lastGrant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = lastGrant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/cpu_alu_ctrl.sv
// Shares the CPU ALU between the execute stage (port 0) and the mining engine (port 1).
// Accepts one op at a time, holds the operands for the op latency, and returns the tagged result.
module cpu_alu_ctrl
  import cpu_alu_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned FLAG_W  = FLAG_W_DEF,
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [7:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [7:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_out,
  output logic [FLAG_W-1:0] resp_flags,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [7:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              busy
);

  localparam int unsigned     CNT_W    = latCntW(ADD_LAT, MUL_LAT);
  localparam logic [CNT_W-1:0] ADD_LAST = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

  aluState_t        state;
  aluState_t        stateNext;
  logic             lastGrant;
  logic [CNT_W-1:0] execCnt;
  logic [1:0]       grant;
  logic             grantId;
  logic             accept;
  logic             execDone;

  cpu_rr_arb2 uArb (
    .req       ({req1_valid, req0_valid}),
    .lastGrant (lastGrant),
    .grant     (grant)
  );

  assign grantId    = grant[1];
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  always_comb begin
    stateNext  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    execDone   = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        accept     = |grant;
        if (accept) stateNext = EXEC;
      end
      EXEC: begin
        // Latency is taken from the already-latched opcode, which is stable here.
        execDone = (execCnt == (alu_op[OP_MUL_BIT] ? MUL_LAST : ADD_LAST));
        if (execDone) stateNext = RESP;
      end
      RESP: begin
        if (resp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lastGrant  <= 1'b1;
      execCnt    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      resp_id    <= 1'b0;
      resp_out   <= '0;
      resp_flags <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        alu_a     <= grantId ? req1_a  : req0_a;
        alu_b     <= grantId ? req1_b  : req0_b;
        alu_op    <= grantId ? req1_op : req0_op;
        resp_id   <= grantId;
        lastGrant <= grantId;
        execCnt   <= '0;
      end else if (state == EXEC) begin
        execCnt <= execCnt + CNT_W'(1);
      end
      if (execDone) begin
        resp_out   <= alu_out;
        resp_flags <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_cpu_alu_ctrl.sv
// Randomized bench for cpu_alu_ctrl against a transaction/timeline reference model.
// The bench also plays the ALU so that results can be predicted from the accepted request.
module tb_cpu_alu_ctrl;
  import cpu_alu_pkg::*;

  localparam int unsigned DW      = 32;
  localparam int unsigned FW      = 32;
  localparam int unsigned ADD_LAT = 1;
  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned NCYC    = 6000;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]    req0_op, req1_op;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          resp_valid, resp_ready, resp_id, busy;
  logic [DW-1:0] resp_out, alu_a, alu_b, alu_out;
  logic [FW-1:0] resp_flags, alu_flags;
  logic [7:0]    alu_op;

  int unsigned nTests = 0;
  int unsigned nFail  = 0;

  always #5 clk = ~clk;

  cpu_alu_ctrl #(
    .DATA_W  (DW),
    .FLAG_W  (FW),
    .ADD_LAT (ADD_LAT),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_out   (resp_out),
    .resp_flags (resp_flags),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .busy       (busy)
  );

  // {flags, out}: flags carry the low result half, the opcode and a zero bit.
  function automatic logic [63:0] refAlu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [7:0] op);
    logic [31:0] r;
    if (op[OP_MUL_BIT])      r = a * b;
    else if (op[OP_SUB_BIT]) r = a - b;
    else                     r = a + b;
    return {r[15:0], op, 7'd0, (r == 32'd0), r};
  endfunction

  always_comb begin
    {alu_flags, alu_out} = refAlu(alu_a, alu_b, alu_op);
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 15));
      1:       return 32'd1000;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [7:0] pickOp();
    case ($urandom_range(0, 4))
      0:       return 8'h00;
      1:       return 8'h02;
      2:       return 8'h04;
      3:       return 8'h06;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Reference model: at most one transaction, described by its accept and response times.
  bit          haveTxn;
  int unsigned tResp;
  logic        lastGrantM;
  logic [31:0] txnOut, txnFlags;
  logic [31:0] expAluA, expAluB, expRespOut, expRespFlags;
  logic [7:0]  expAluOp;
  logic        expRespId;
  logic        expRdy0, expRdy1, expRespValid;
  logic [63:0] res;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    req0_op = '0; req1_op = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    haveTxn = 1'b0; tResp = 0; lastGrantM = 1'b1;
    txnOut = '0; txnFlags = '0;
    expAluA = '0; expAluB = '0; expAluOp = '0;
    expRespOut = '0; expRespFlags = '0; expRespId = 1'b0;

    for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rst = (cyc < 2) || ($urandom_range(0, 79) == 0);
      if (cyc < 300) begin
        // Contention phase: both ports always requesting, consumer always ready.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        resp_ready = 1'b1;
      end else begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req1_valid = ($urandom_range(0, 9) < 4);
        resp_ready = ($urandom_range(0, 9) < 4);
      end
      req0_a = pickOperand(); req0_b = pickOperand(); req0_op = pickOp();
      req1_a = pickOperand(); req1_b = pickOperand(); req1_op = pickOp();
      #1;

      if (haveTxn && cyc == tResp) begin
        expRespOut   = txnOut;
        expRespFlags = txnFlags;
      end
      expRdy0      = !haveTxn && req0_valid && (!req1_valid || lastGrantM);
      expRdy1      = !haveTxn && req1_valid && (!req0_valid || !lastGrantM);
      expRespValid = haveTxn && (cyc >= tResp);

      if (cyc > 0) begin
        if (!rst) begin
          checkVal("req0_ready", req0_ready, expRdy0);
          checkVal("req1_ready", req1_ready, expRdy1);
        end
        checkVal("resp_valid", resp_valid, expRespValid);
        checkVal("busy",       busy,       haveTxn);
        checkVal("alu_a",      alu_a,      expAluA);
        checkVal("alu_b",      alu_b,      expAluB);
        checkVal("alu_op",     alu_op,     expAluOp);
        checkVal("resp_id",    resp_id,    expRespId);
        checkVal("resp_out",   resp_out,   expRespOut);
        checkVal("resp_flags", resp_flags, expRespFlags);
      end

      if (rst) begin
        haveTxn = 1'b0; lastGrantM = 1'b1;
        expAluA = '0; expAluB = '0; expAluOp = '0;
        expRespOut = '0; expRespFlags = '0; expRespId = 1'b0;
      end else if (expRespValid && resp_ready) begin
        haveTxn = 1'b0;
      end else if (expRdy0 || expRdy1) begin
        expRespId  = expRdy1;
        lastGrantM = expRdy1;
        expAluA    = expRdy1 ? req1_a  : req0_a;
        expAluB    = expRdy1 ? req1_b  : req0_b;
        expAluOp   = expRdy1 ? req1_op : req0_op;
        res        = refAlu(expAluA, expAluB, expAluOp);
        txnOut     = res[31:0];
        txnFlags   = res[63:32];
        tResp      = cyc + (expAluOp[OP_MUL_BIT] ? MUL_LAT : ADD_LAT) + 1;
        haveTxn    = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
